// File: rtl/cell_tx_arbiter_if.sv
// rtl/cell_tx_arbiter_if.sv - request/ack and UART byte handshake bundle for cell_tx_arbiter
// master is the arbiter side; slave is the requesters plus UART side.
interface cell_tx_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 4
);
   localparam int MESSAGE_WIDTH = 2*(ADDR_WIDTH+1)+4;

   logic [NUM_REQ-1:0]               req;
   logic [NUM_REQ*MESSAGE_WIDTH-1:0] msg;
   logic [NUM_REQ-1:0]               ack;
   logic [7:0]                       txdata;
   logic                             send;
   logic                             txdone;

   modport master (
      input  req,
      input  msg,
      output ack,
      output txdata,
      output send,
      input  txdone
   );

   modport slave (
      output req,
      output msg,
      input  ack,
      input  txdata,
      input  send,
      output txdone
   );
endinterface

// File: rtl/cell_tx_arbiter.sv
// rtl/cell_tx_arbiter.sv - cell-to-UART message arbiter; define CELL_TX_ARB_FIXED_PRIO_EN for fixed priority
// Captures one requester's message and serialises it as bytes i, j, status.
module cell_tx_arbiter #(
   parameter  int NUM_REQ       = 4,
   parameter  int ADDR_WIDTH    = 4,
   localparam int MESSAGE_WIDTH = 2*(ADDR_WIDTH+1)+4,
   localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   cell_tx_arbiter_if.master     cell_if,
   output logic                  busy_o,
   output logic [GW-1:0]         grant_id_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [NUM_REQ-1:0]       ack_q, ack_d;
   logic                     send_q, send_d;
   logic [7:0]               txdata_q, txdata_d;
   logic                     busy_q, busy_d;
   logic [GW-1:0]            grant_q, grant_d;
   logic [1:0]               byte_idx_q, byte_idx_d;
   logic [MESSAGE_WIDTH-1:0] msg_q, msg_d;
`ifndef CELL_TX_ARB_FIXED_PRIO_EN
   logic [GW-1:0]            last_grant_q, last_grant_d;
`endif

   logic [MESSAGE_WIDTH-1:0] msg_arr [NUM_REQ];
   logic [GW-1:0]            winner;
   logic                     any_req;
   logic [7:0]               tx_byte;
   logic                     unused_pad;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_msg
      assign msg_arr[g] = cell_if.msg[g*MESSAGE_WIDTH +: MESSAGE_WIDTH];
   end

   assign any_req    = |cell_if.req;
   assign unused_pad = msg_q[4] ^ msg_q[ADDR_WIDTH+5];

   // Descending scan so the requester found first in search order is written last.
`ifdef CELL_TX_ARB_FIXED_PRIO_EN
   always_comb begin
      winner = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         if (cell_if.req[GW'(k)]) winner = GW'(k);
      end
   end
`else
   always_comb begin
      int idx;
      winner = '0;
      idx    = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = int'(last_grant_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (cell_if.req[GW'(idx)]) winner = GW'(idx);
      end
   end
`endif

   always_comb begin
      case (byte_idx_q)
         2'd0:    tx_byte = 8'(msg_q[ADDR_WIDTH+6 +: ADDR_WIDTH]);
         2'd1:    tx_byte = 8'(msg_q[5 +: ADDR_WIDTH]);
         default: tx_byte = {4'b0000, msg_q[3:0]};
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         ack_q        <= '0;
         send_q       <= 1'b0;
         txdata_q     <= '0;
         busy_q       <= 1'b0;
         grant_q      <= '0;
         byte_idx_q   <= '0;
         msg_q        <= '0;
`ifndef CELL_TX_ARB_FIXED_PRIO_EN
         last_grant_q <= GW'(NUM_REQ-1);
`endif
      end else begin
         state_q      <= state_d;
         ack_q        <= ack_d;
         send_q       <= send_d;
         txdata_q     <= txdata_d;
         busy_q       <= busy_d;
         grant_q      <= grant_d;
         byte_idx_q   <= byte_idx_d;
         msg_q        <= msg_d;
`ifndef CELL_TX_ARB_FIXED_PRIO_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (any_req) state_d = ST_SEND;
         ST_SEND: state_d = ST_WAIT;
         ST_WAIT: begin
            if (cell_if.txdone) state_d = (byte_idx_q == 2'd2) ? ST_IDLE : ST_SEND;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered, so ack (entering SEND) and send (leaving SEND) never coincide.
   always_comb begin
      ack_d        = '0;
      send_d       = 1'b0;
      txdata_d     = txdata_q;
      busy_d       = busy_q;
      grant_d      = grant_q;
      byte_idx_d   = byte_idx_q;
      msg_d        = msg_q;
`ifndef CELL_TX_ARB_FIXED_PRIO_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               ack_d[winner] = 1'b1;
               msg_d         = msg_arr[winner];
               grant_d       = winner;
               busy_d        = 1'b1;
               byte_idx_d    = 2'd0;
`ifndef CELL_TX_ARB_FIXED_PRIO_EN
               last_grant_d  = winner;
`endif
            end
         end
         ST_SEND: begin
            send_d   = 1'b1;
            txdata_d = tx_byte;
         end
         ST_WAIT: begin
            if (cell_if.txdone) begin
               if (byte_idx_q == 2'd2) busy_d = 1'b0;
               else                    byte_idx_d = byte_idx_q + 2'd1;
            end
         end
         default: ;
      endcase
   end

   assign cell_if.ack    = ack_q;
   assign cell_if.send   = send_q;
   assign cell_if.txdata = txdata_q;
   assign busy_o         = busy_q;
   assign grant_id_o     = grant_q;

endmodule

// File: tb/tb_cell_tx_arbiter.sv
// tb/tb_cell_tx_arbiter.sv - randomized self-checking bench for cell_tx_arbiter
// Transaction-level model: pending set, last grant and per-cell fields predict each message.
module tb_cell_tx_arbiter;
   localparam int NUM_REQ    = 4;
   localparam int ADDR_WIDTH = 4;
   localparam int MW         = 2*(ADDR_WIDTH+1)+4;
   localparam int GW         = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          busy;
   logic [GW-1:0] grant_id;

   cell_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH)) cell_if ();

   cell_tx_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .cell_if    (cell_if),
      .busy_o     (busy),
      .grant_id_o (grant_id)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int sends_seen = 0;
   int exp_sends  = 0;
   int grants[$];
   int rr_exp [5];

   logic [NUM_REQ-1:0] pend;
   logic [3:0]         fi [NUM_REQ];
   logic [3:0]         fj [NUM_REQ];
   logic [3:0]         fs [NUM_REQ];
   int                 last_m;

   always @(negedge clk) if (cell_if.send === 1'b1) sends_seen++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int pick(input logic [NUM_REQ-1:0] p);
`ifdef CELL_TX_ARB_FIXED_PRIO_EN
      for (int k = 0; k < NUM_REQ; k++) if (p[k]) return k;
`else
      for (int off = 1; off <= NUM_REQ; off++)
         if (p[(last_m+off) % NUM_REQ]) return (last_m+off) % NUM_REQ;
`endif
      return 0;
   endfunction

   task automatic set_req(input int k, input logic [3:0] i, input logic [3:0] j, input logic [3:0] s);
      fi[k] = i;
      fj[k] = j;
      fs[k] = s;
      cell_if.msg[k*MW +: MW] = {i, 1'b0, j, 1'b0, s};
      pend[k] = 1'b1;
      cell_if.req = pend;
   endtask

   task automatic set_rand_req(input int k);
      set_req(k, 4'($urandom), 4'($urandom), 4'($urandom));
   endtask

   task automatic reset_checks();
      chk("rst_busy", busy, 0);
      chk("rst_send", cell_if.send, 0);
      chk("rst_ack", cell_if.ack, 0);
      chk("rst_txdata", cell_if.txdata, 0);
      chk("rst_grant", grant_id, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cell_if.txdone = 1'b0;
      pend = '0;
      cell_if.req = pend;
      #1;
      reset_checks();
      tick();
      rst = 1'b0;
      last_m = NUM_REQ-1;
   endtask

   task automatic idle_cycles(input int n, input bit spurious);
      for (int c = 0; c < n; c++) begin
         cell_if.txdone = spurious;
         tick();
         chk("idle_ack", cell_if.ack, 0);
         chk("idle_send", cell_if.send, 0);
         chk("idle_busy", busy, 0);
      end
      cell_if.txdone = 1'b0;
   endtask

   // Entered in a cycle where the DUT is idle and pend is non-empty.
   task automatic run_message(input int dly, input bit spurious, input bit abort,
                              input bit reraise, input bit wander);
      int         w;
      int         d;
      logic [7:0] exp [3];
      w = pick(pend);
      exp[0] = {4'b0000, fi[w]};
      exp[1] = {4'b0000, fj[w]};
      exp[2] = {4'b0000, fs[w]};
      chk("pre_busy", busy, 0);
      cell_if.txdone = spurious;
      tick();
      cell_if.txdone = spurious;
      chk("ack", cell_if.ack, 1 << w);
      chk("grant", grant_id, w);
      chk("busy_set", busy, 1);
      chk("ack_no_send", cell_if.send, 0);
      grants.push_back(int'(grant_id));
      last_m = w;
      pend[w] = 1'b0;
      cell_if.req = pend;
      if (reraise) set_rand_req(w);
      for (int b = 0; b < 3; b++) begin
         tick();
         cell_if.txdone = 1'b0;
         chk("send", cell_if.send, 1);
         chk("txdata", cell_if.txdata, exp[b]);
         chk("send_no_ack", cell_if.ack, 0);
         d = (dly > 0) ? dly : $urandom_range(1, 5);
         if (abort && b == 1) begin
            tick();
            rst = 1'b1;
            #1;
            reset_checks();
            tick();
            rst = 1'b0;
            last_m = NUM_REQ-1;
            exp_sends += 2;
            return;
         end
         for (int c = 1; c < d; c++) begin
            tick();
            chk("wait_quiet", cell_if.send, 0);
            chk("txdata_hold", cell_if.txdata, exp[b]);
            if (wander && $urandom_range(0, 3) == 0) set_rand_req($urandom_range(0, NUM_REQ-1));
         end
         tick();
         cell_if.txdone = 1'b1;
         chk("busy_wait", busy, 1);
         tick();
         cell_if.txdone = 1'b0;
         chk("post_txdone_send", cell_if.send, 0);
         if (b == 2) begin
            chk("busy_clear", busy, 0);
            chk("txdata_last", cell_if.txdata, exp[2]);
         end
      end
      exp_sends += 3;
   endtask

   initial begin
      rst = 1'b1;
      pend = '0;
      cell_if.req = '0;
      cell_if.msg = '0;
      cell_if.txdone = 1'b0;
      last_m = NUM_REQ-1;
`ifdef CELL_TX_ARB_FIXED_PRIO_EN
      rr_exp = '{0, 0, 0, 0, 0};
`else
      rr_exp = '{0, 1, 2, 3, 0};
`endif

      tick();
      cell_if.req = '1;
      tick();
      reset_checks();
      tick();
      chk("rst_ack_held", cell_if.ack, 0);
      cell_if.req = '0;
      rst = 1'b0;

      set_req(2, 4'd3, 4'd5, 4'd9);
      run_message(4, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("single_grant", grants[$], 2);
      idle_cycles(4, 1'b1);

      do_reset();
      grants.delete();
      for (int k = 0; k < NUM_REQ; k++) set_rand_req(k);
      for (int n = 0; n < 5; n++) run_message(0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int n = 0; n < 5; n++) chk("rr_order", grants[n], rr_exp[n]);

      run_message(0, 1'b1, 1'b0, 1'b1, 1'b0);
      run_message(0, 1'b0, 1'b1, 1'b0, 1'b0);
      run_message(0, 1'b0, 1'b0, 1'b0, 1'b0);

      do_reset();
      set_rand_req(0);
      set_rand_req(1);
      run_message(3, 1'b0, 1'b0, 1'b0, 1'b0);
      run_message(3, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int n = 0; n < 30; n++) begin
         if (pend == '0) begin
            idle_cycles($urandom_range(1, 3), 1'($urandom_range(0, 1)));
            for (int r = 0; r < int'($urandom_range(1, 4)); r++)
               set_rand_req($urandom_range(0, NUM_REQ-1));
         end
         run_message(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                     1'($urandom_range(0, 1)), 1'b1);
      end

      tick();
      chk("send_count", sends_seen, exp_sends);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cell_tx_arbiter.md
CELL_TX_ARBITER -- requirements
Module: cell_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of cell requesters sharing the UART transmit path.
REQ-002 Parameter ADDR_WIDTH, default 4: width of the row index i and the column index j; MESSAGE_WIDTH = 2*(ADDR_WIDTH+1)+4 (14 at default).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  NUM_REQ  level request per cell; held until that cell's ack.
REQ-006 msg  input  NUM_REQ*MESSAGE_WIDTH  flattened messages; requester k occupies bits [k*MESSAGE_WIDTH +: MESSAGE_WIDTH].
REQ-007 ack  output  NUM_REQ  one-cycle pulse; message of requester k has been captured.
REQ-008 txdata  output  8  byte presented to the UART transmitter.
REQ-009 send  output  1  one-cycle strobe; UART starts sending txdata.
REQ-010 txdone  input  1  one-cycle pulse from the UART; current byte finished.
REQ-011 busy  output  1  high from message capture until the last txdone.
REQ-012 grant_id  output  clog2(NUM_REQ)  index of the requester being served; holds its last value while idle.

Function
REQ-013 Message layout: {i[ADDR_WIDTH-1:0], 1'b0, j[ADDR_WIDTH-1:0], 1'b0, status[3:0]}, with i in the MSBs.
REQ-014 The message is serialised as three bytes in order i, j, status; each byte is zero-extended in its upper bits.
REQ-015 FSM states: IDLE, SEND, WAIT.
REQ-016 IDLE, any req high: select the winner; latch its msg; pulse ack[winner] for one cycle; set grant_id; set busy; set byte_idx=0; go to SEND.
REQ-017 SEND: drive txdata with byte[byte_idx]; pulse send for one cycle; go to WAIT.
REQ-018 WAIT, txdone with byte_idx<2: increment byte_idx; go to SEND.
REQ-019 WAIT, txdone with byte_idx==2: clear busy; go to IDLE.
REQ-020 Timing: req high at edge N gives ack and busy at N+1; first send at N+2; next send one cycle after each txdone.
REQ-021 txdata holds its value between send strobes and after the third byte.
REQ-022 txdone received in IDLE or SEND is ignored.
REQ-023 req changes after capture do not affect the message in flight.
REQ-024 Round-robin selection: search starts at last_grant+1 modulo NUM_REQ; the first requester found with req high wins; last_grant updates on capture.
REQ-025 IDLE with no req: no ack, send, or state change.
REQ-026 Back-to-back: from IDLE after the final txdone, a pending request is captured at the next edge (one idle cycle minimum).
REQ-027 At most one ack bit is high in any cycle; ack and send are never high in the same cycle.

Reset
REQ-028 While rst is high, regardless of state:
- state = IDLE
- ack = 0, send = 0, busy = 0
- txdata = 0, grant_id = 0, byte_idx = 0
- last_grant = NUM_REQ-1, so requester 0 wins first
REQ-029 A reset asserted mid-message abandons the message; no further send is issued, and the unsent bytes are not retried.

Configuration
REQ-030 Macro CELL_TX_ARB_FIXED_PRIO_EN defined: fixed priority replaces REQ-024; the lowest requester index with req high always wins; last_grant is unused.
REQ-031 Macro CELL_TX_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-024.

Verification
REQ-032 Single request: req=4'b0100, msg[2] with i=3, j=5, status=9, txdone 4 cycles after each send -> ack=4'b0100 once, grant_id=2, txdata sequence 0x03, 0x05, 0x09, busy low after the third txdone.
REQ-033 Round-robin: req=4'b1111 held, re-raised after each ack -> grant order 0,1,2,3,0. With the macro defined -> order 0,0,0.
REQ-034 Spurious txdone: txdone pulsed in IDLE and in SEND -> byte_idx unchanged, exactly 3 sends per message.
REQ-035 Reset mid-message: rst pulsed in WAIT after the second byte -> busy=0, send=0, state IDLE; the next request starts again at byte i.
REQ-036 Back-to-back: req[1] held through req[0]'s message -> ack[1] exactly 2 cycles after the final txdone of message 0, with one idle cycle between.
